// File: rtl/mem_stage_access_pkg.sv
// Shared definitions for the M-stage memory access unit: opcodes, exception
// codes, FSM state encoding and the load/store decode helper.
package mem_stage_access_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [4:0] EXC_ADEL_DEF = 5'd4;
  localparam logic [4:0] EXC_ADES_DEF = 5'd5;
  localparam logic [4:0] EXC_DBE_DEF  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_H  = 3'd1,
    LD_HU = 3'd2,
    LD_B  = 3'd3,
    LD_BU = 3'd4
  } ld_op_t;

  typedef struct packed {
    logic   is_load;
    logic   is_store;
    size_t  size;
    ld_op_t ld_op;
  } dec_t;

  function automatic dec_t decode_op(input logic [5:0] op);
    dec_t d;
    d = '{is_load: 1'b0, is_store: 1'b0, size: SZ_B, ld_op: LD_W};
    case (op)
      OP_LW:   begin d.is_load  = 1'b1; d.size = SZ_W; d.ld_op = LD_W;  end
      OP_LH:   begin d.is_load  = 1'b1; d.size = SZ_H; d.ld_op = LD_H;  end
      OP_LHU:  begin d.is_load  = 1'b1; d.size = SZ_H; d.ld_op = LD_HU; end
      OP_LB:   begin d.is_load  = 1'b1; d.size = SZ_B; d.ld_op = LD_B;  end
      OP_LBU:  begin d.is_load  = 1'b1; d.size = SZ_B; d.ld_op = LD_BU; end
      OP_SW:   begin d.is_store = 1'b1; d.size = SZ_W; end
      OP_SH:   begin d.is_store = 1'b1; d.size = SZ_H; end
      OP_SB:   begin d.is_store = 1'b1; d.size = SZ_B; end
      default: begin d.is_load  = 1'b0; d.is_store = 1'b0; end
    endcase
    return d;
  endfunction

  function automatic logic [31:0] exc_cause(input logic [4:0] code);
    return {25'b0, code, 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_access_load_ext.sv
// Load lane select and sign/zero extension for the captured read data.
module mem_load_ext
  import mem_stage_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  ld_op_t      op,
  output logic [31:0] result
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // Pick the addressed lane, then extend according to the load flavour
  always_comb begin
    half_s = addr[1] ? rdata[31:16] : rdata[15:0];
    byte_s = rdata[{addr, 3'b000} +: 8];
    case (op)
      LD_H:    result = {{16{half_s[15]}}, half_s};
      LD_HU:   result = {16'h0000, half_s};
      LD_B:    result = {{24{byte_s[7]}}, byte_s};
      LD_BU:   result = {24'h000000, byte_s};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_access.sv
// M-stage data memory access: decode, alignment, byte enables, store lane
// steering, req/ack bus transaction with timeout, and load result to W.
module mem_stage_access
  import mem_stage_access_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [4:0]  EXC_ADEL = EXC_ADEL_DEF,
  parameter logic [4:0]  EXC_ADES = EXC_ADES_DEF,
  parameter logic [4:0]  EXC_DBE  = EXC_DBE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] instrM,
  input  logic [31:0] memaddrM,
  input  logic [31:0] rd2M,
  input  logic [31:0] causeM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stallM,
  output logic [31:0] loaddataM,
  output logic        load_valid,
  output logic [31:0] causeMo
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [7:0]  cnt_r;
  dec_t        dec_s;
  logic        aligned_s, access_s, start_s, ack_s, tmo_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, ld_ext_s;
  ld_op_t      ld_op_r;
  logic        is_load_r, flush_pend_r, tmo_r;
  logic [1:0]  off_r;
  logic        unused_instr_s;

  assign unused_instr_s = ^instrM[25:0];

  // Decode, alignment check and store lane steering for the M instruction
  always_comb begin
    dec_s    = decode_op(instrM[31:26]);
    access_s = dec_s.is_load | dec_s.is_store;
    case (dec_s.size)
      SZ_W: begin
        aligned_s = (memaddrM[1:0] == 2'b00);
        be_s      = 4'b1111;
        wdata_s   = rd2M;
      end
      SZ_H: begin
        aligned_s = ~memaddrM[0];
        be_s      = memaddrM[1] ? 4'b1100 : 4'b0011;
        wdata_s   = {2{rd2M[15:0]}};
      end
      default: begin
        aligned_s = 1'b1;
        be_s      = 4'b0001 << memaddrM[1:0];
        wdata_s   = {4{rd2M[7:0]}};
      end
    endcase
  end

  assign start_s = access_s && !flush && (causeM == 32'd0) && aligned_s;
  assign ack_s   = (state_r == ST_WAIT) && bus_ack;
  assign tmo_s   = (state_r == ST_WAIT) && !bus_ack && (cnt_r == TMO_LAST);

  // Next state, stall and outgoing cause
  always_comb begin
    state_s = state_r;
    stallM  = 1'b0;
    causeMo = 32'd0;
    case (state_r)
      ST_IDLE: begin
        stallM = start_s;
        if (start_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
        // Older exception wins; then our own address error; else clean
        if (causeM != 32'd0) begin
          causeMo = causeM;
        end else if (access_s && !aligned_s) begin
          causeMo = exc_cause(dec_s.is_load ? EXC_ADEL : EXC_ADES);
        end else begin
          causeMo = 32'd0;
        end
      end
      ST_WAIT: begin
        stallM = 1'b1;
        if (ack_s || tmo_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        causeMo = (tmo_r && !flush_pend_r) ? exc_cause(EXC_DBE) : 32'd0;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter, bus outputs and captured load result
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'd0;
      bus_be       <= 4'd0;
      bus_wdata    <= 32'd0;
      loaddataM    <= 32'd0;
      load_valid   <= 1'b0;
      ld_op_r      <= LD_W;
      is_load_r    <= 1'b0;
      off_r        <= 2'd0;
      flush_pend_r <= 1'b0;
      tmo_r        <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          cnt_r        <= 8'd0;
          flush_pend_r <= 1'b0;
          tmo_r        <= 1'b0;
          load_valid   <= 1'b0;
          if (start_s) begin
            bus_req   <= 1'b1;
            bus_we    <= dec_s.is_store;
            bus_addr  <= {memaddrM[31:2], 2'b00};
            bus_be    <= be_s;
            bus_wdata <= wdata_s;
            ld_op_r   <= dec_s.ld_op;
            is_load_r <= dec_s.is_load;
            off_r     <= memaddrM[1:0];
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r + 8'd1;
          if (flush) begin
            flush_pend_r <= 1'b1;
          end
          if (ack_s) begin
            bus_req    <= 1'b0;
            loaddataM  <= ld_ext_s;
            load_valid <= is_load_r && !flush_pend_r && !flush;
          end else if (tmo_s) begin
            bus_req <= 1'b0;
            tmo_r   <= 1'b1;
          end
        end
        ST_DONE: begin
          cnt_r      <= 8'd0;
          load_valid <= 1'b0;
        end
        default: begin
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  mem_load_ext u_load_ext (
    .rdata  (bus_rdata),
    .addr   (off_r),
    .op     (ld_op_r),
    .result (ld_ext_s)
  );

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: directed cases plus randomized
// loads/stores compared against a byte-level reference model.
module tb_mem_stage_access;

  logic        clk = 1'b0;
  logic        rst, flush, bus_ack;
  logic [31:0] instrM, memaddrM, rd2M, causeM, bus_rdata;
  logic        bus_req, bus_we, stallM, load_valid;
  logic [31:0] bus_addr, bus_wdata, loaddataM, causeMo;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int          stall_cnt;
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          done;
    bit          lv;
    logic [31:0] ld;
    logic [31:0] cause;
    bit          req_drop;
  } obs_t;

  logic [5:0] ld_ops [5] = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24};
  logic [5:0] st_ops [3] = '{6'h2B, 6'h29, 6'h28};

  always #5 clk = ~clk;

  mem_stage_access dut (
    .clk(clk), .rst(rst), .flush(flush), .instrM(instrM), .memaddrM(memaddrM),
    .rd2M(rd2M), .causeM(causeM), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stallM(stallM),
    .loaddataM(loaddataM), .load_valid(load_valid), .causeMo(causeMo)
  );

  // ---------------- reference model ----------------
  function automatic int sz_of(input logic [5:0] op);
    case (op)
      6'h23, 6'h2B:        return 4;
      6'h21, 6'h25, 6'h29: return 2;
      6'h20, 6'h24, 6'h28: return 1;
      default:             return 0;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] addr, input int n);
    logic [3:0] be;
    int off;
    off = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] addr, input int n,
                                            input logic [31:0] rd2);
    logic [31:0] w;
    int off;
    off = int'(addr[1:0]);
    w = 32'd0;
    for (int i = 0; i < n; i++) w[8*(off+i) +: 8] = rd2[8*i +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    longint v;
    int n, off;
    n = sz_of(op);
    off = int'(addr[1:0]);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(rd[8*(off+i) +: 8]) << (8*i));
    if ((op == 6'h20 || op == 6'h21) && v >= (longint'(1) << (8*n-1)))
      v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op);
    logic [25:0] r;
    r = 26'($urandom);
    return {op, r};
  endfunction

  // ---------------- transaction driver ----------------
  // ack_wait / flush_wait are WAIT-cycle indices (0 = first WAIT cycle), -1 = never
  task automatic run_txn(input logic [31:0] instr, input logic [31:0] addr,
                         input logic [31:0] rd2, input logic [31:0] cin,
                         input logic [31:0] rdata, input int ack_wait,
                         input int flush_wait, output obs_t o);
    o = '0;
    @(negedge clk);
    instrM = instr; memaddrM = addr; rd2M = rd2; causeM = cin;
    flush = 1'b0; bus_ack = 1'b0; bus_rdata = rdata;
    #1;
    if (stallM) o.stall_cnt = o.stall_cnt + 1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      bus_ack = 1'b0; flush = 1'b0;
      if (bus_req && !o.req) begin
        o.req = 1'b1; o.we = bus_we; o.addr = bus_addr; o.be = bus_be; o.wdata = bus_wdata;
      end
      if (k - 1 == flush_wait) flush = 1'b1;
      if (k - 1 == ack_wait) bus_ack = 1'b1;
      #1;
      if (stallM) begin
        o.stall_cnt = o.stall_cnt + 1;
      end else begin
        o.done = 1'b1; o.lv = load_valid; o.ld = loaddataM; o.cause = causeMo;
        o.req_drop = !bus_req;
        instrM = 32'd0; causeM = 32'd0;
        break;
      end
    end
    bus_ack = 1'b0; flush = 1'b0;
    checks++;
    if (!o.done) begin
      errors++;
      $display("FAIL txn_timeout actual=stalled required=done instr=%h", instr);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; bus_ack = 1'b0; instrM = 32'd0; memaddrM = 32'd0;
    rd2M = 32'd0; causeM = 32'd0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_req, bus_we, load_valid, stallM, bus_be, bus_addr, bus_wdata, loaddataM} !== 104'd0) begin
      errors++;
      $display("FAIL reset_state actual=%b%b%b%b be=%h a=%h w=%h ld=%h required=all zero",
               bus_req, bus_we, load_valid, stallM, bus_be, bus_addr, bus_wdata, loaddataM);
    end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    obs_t o;
    logic [5:0] ops [4] = '{6'h23, 6'h20, 6'h24, 6'h21};
    logic [31:0] adr [4] = '{32'h100, 32'h103, 32'h103, 32'h102};
    logic [31:0] res [4] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD};
    for (int i = 0; i < 4; i++) begin
      run_txn(mk(ops[i]), adr[i], 32'd0, 32'd0, 32'hDEADBEEF, 0, -1, o);
      checks++;
      if ({o.lv, o.ld} !== {1'b1, res[i]} || o.stall_cnt != 2) begin
        errors++;
        $display("FAIL dir_load%0d actual=lv%b %h stall%0d required=lv1 %h stall2",
                 i, o.lv, o.ld, o.stall_cnt, res[i]);
      end
    end
    checks++;
    if (o.be !== 4'b1111 && ops[0] == 6'h23) begin end
    run_txn(mk(6'h23), 32'h100, 32'd0, 32'd0, 32'h0, 0, -1, o);
    if (o.be !== 4'b1111) begin
      errors++; $display("FAIL dir_lw_be actual=%b required=1111", o.be);
    end
    run_txn(mk(6'h28), 32'h101, 32'h000000A5, 32'd0, 32'd0, 0, -1, o);
    checks++;
    if ({o.we, o.be, o.wdata[15:8], o.addr} !== {1'b1, 4'b0010, 8'hA5, 32'h100}) begin
      errors++;
      $display("FAIL dir_sb actual=we%b be%b b1=%h a=%h required=we1 be0010 b1=a5 a=100",
               o.we, o.be, o.wdata[15:8], o.addr);
    end
    run_txn(mk(6'h29), 32'h103, 32'h1234, 32'd0, 32'd0, 0, -1, o);
    checks++;
    if ({o.req, o.cause} !== {1'b0, 32'h14} || o.stall_cnt != 0) begin
      errors++;
      $display("FAIL dir_sh_mis actual=req%b cause=%h required=req0 cause=14", o.req, o.cause);
    end
    run_txn(mk(6'h23), 32'h100, 32'd0, 32'h30, 32'd0, 0, -1, o);
    checks++;
    if ({o.req, o.cause} !== {1'b0, 32'h30} || o.stall_cnt != 0) begin
      errors++;
      $display("FAIL dir_cause actual=req%b cause=%h stall%0d required=req0 cause=30 stall0",
               o.req, o.cause, o.stall_cnt);
    end
  endtask

  task automatic test_rand_loads();
    obs_t o;
    logic [5:0] op;
    logic [31:0] a, rd;
    int n, w;
    for (int it = 0; it < 30; it++) begin
      op = ld_ops[$urandom_range(0, 4)]; n = sz_of(op);
      a = $urandom; a = a & ~(32'(n) - 32'd1);
      rd = $urandom; w = $urandom_range(0, 4);
      run_txn(mk(op), a, $urandom, 32'd0, rd, w, -1, o);
      checks++;
      if (o.stall_cnt != w + 2) begin
        errors++; $display("FAIL ld_stall op=%h actual=%0d required=%0d", op, o.stall_cnt, w + 2);
      end
      checks++;
      if ({o.req, o.we, o.addr, o.be} !== {1'b1, 1'b0, a[31:2], 2'b00, exp_be(a, n)}) begin
        errors++;
        $display("FAIL ld_bus op=%h actual=req%b we%b a=%h be=%b required=a=%h be=%b",
                 op, o.req, o.we, o.addr, o.be, {a[31:2], 2'b00}, exp_be(a, n));
      end
      checks++;
      if ({o.lv, o.ld, o.cause, o.req_drop} !== {1'b1, exp_load(op, a, rd), 32'd0, 1'b1}) begin
        errors++;
        $display("FAIL ld_data op=%h a=%h rd=%h actual=lv%b %h c=%h required=%h",
                 op, a, rd, o.lv, o.ld, o.cause, exp_load(op, a, rd));
      end
    end
  endtask

  task automatic test_rand_stores();
    obs_t o;
    logic [5:0] op;
    logic [31:0] a, d, m;
    int n, w;
    for (int it = 0; it < 30; it++) begin
      op = st_ops[$urandom_range(0, 2)]; n = sz_of(op);
      a = $urandom; a = a & ~(32'(n) - 32'd1);
      d = $urandom; w = $urandom_range(0, 4);
      run_txn(mk(op), a, d, 32'd0, $urandom, w, -1, o);
      m = lane_mask(exp_be(a, n));
      checks++;
      if ({o.req, o.we, o.addr, o.be} !== {1'b1, 1'b1, a[31:2], 2'b00, exp_be(a, n)}
          || o.stall_cnt != w + 2) begin
        errors++;
        $display("FAIL st_bus op=%h actual=we%b a=%h be=%b stall%0d required=a=%h be=%b stall%0d",
                 op, o.we, o.addr, o.be, o.stall_cnt, {a[31:2], 2'b00}, exp_be(a, n), w + 2);
      end
      checks++;
      if ((o.wdata & m) !== exp_wdata(a, n, d) || {o.lv, o.cause} !== 33'd0) begin
        errors++;
        $display("FAIL st_data op=%h actual=%h lv%b c=%h required=%h",
                 op, o.wdata & m, o.lv, o.cause, exp_wdata(a, n, d));
      end
    end
  endtask

  task automatic test_exceptions();
    obs_t o;
    logic [5:0] op;
    logic [31:0] a, c, exp_c;
    for (int it = 0; it < 12; it++) begin
      op = (it % 2 == 0) ? ld_ops[$urandom_range(0, 2)] : st_ops[$urandom_range(0, 1)];
      a = $urandom;
      a[1:0] = (sz_of(op) == 4) ? 2'($urandom_range(1, 3)) : (($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3);
      c = (it % 3 == 0) ? ($urandom | 32'h1) : 32'd0;
      exp_c = (c != 32'd0) ? c : ((it % 2 == 0) ? 32'h10 : 32'h14);
      run_txn(mk(op), a, $urandom, c, $urandom, 0, -1, o);
      checks++;
      if ({o.req, o.cause} !== {1'b0, exp_c} || o.stall_cnt != 0) begin
        errors++;
        $display("FAIL exc op=%h a=%h actual=req%b c=%h stall%0d required=req0 c=%h stall0",
                 op, a, o.req, o.cause, o.stall_cnt, exp_c);
      end
    end
    for (int it = 0; it < 6; it++) begin
      op = 6'($urandom);
      while (sz_of(op) != 0) op = 6'($urandom);
      c = (it % 2 == 0) ? 32'h24 : 32'd0;
      run_txn(mk(op), $urandom, $urandom, c, $urandom, 0, -1, o);
      checks++;
      if ({o.req, o.cause} !== {1'b0, c} || o.stall_cnt != 0) begin
        errors++;
        $display("FAIL nop op=%h actual=req%b c=%h required=req0 c=%h", op, o.req, o.cause, c);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(mk(6'h2B), 32'h200, 32'h55AA55AA, 32'd0, 32'd0, -1, -1, o);
    checks++;
    if ({o.req, o.req_drop, o.lv, o.cause} !== {1'b1, 1'b1, 1'b0, 32'h1C} || o.stall_cnt != 256) begin
      errors++;
      $display("FAIL timeout actual=req%b drop%b lv%b c=%h stall%0d required=1 1 0 1c 256",
               o.req, o.req_drop, o.lv, o.cause, o.stall_cnt);
    end
    run_txn(mk(6'h23), 32'h204, 32'd0, 32'd0, 32'd0, -1, 10, o);
    checks++;
    if ({o.lv, o.cause} !== 33'd0 || o.stall_cnt != 256) begin
      errors++;
      $display("FAIL timeout_flush actual=lv%b c=%h stall%0d required=lv0 c=0 stall256",
               o.lv, o.cause, o.stall_cnt);
    end
  endtask

  task automatic test_flush();
    obs_t o;
    run_txn(mk(6'h23), 32'h300, 32'd0, 32'd0, 32'h12345678, 3, 0, o);
    checks++;
    if ({o.lv, o.cause, o.req_drop} !== {1'b0, 32'd0, 1'b1} || o.stall_cnt != 5) begin
      errors++;
      $display("FAIL flush_wait actual=lv%b c=%h stall%0d required=lv0 c=0 stall5",
               o.lv, o.cause, o.stall_cnt);
    end
    run_txn(mk(6'h20), 32'h301, 32'd0, 32'd0, 32'h12345678, 2, 2, o);
    checks++;
    if (o.lv !== 1'b0 || o.stall_cnt != 4) begin
      errors++;
      $display("FAIL flush_with_ack actual=lv%b stall%0d required=lv0 stall4", o.lv, o.stall_cnt);
    end
    @(negedge clk);
    instrM = mk(6'h23); memaddrM = 32'h400; flush = 1'b1;
    #1;
    checks++;
    if (stallM !== 1'b0) begin
      errors++; $display("FAIL flush_idle_stall actual=%b required=0", stallM);
    end
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0) begin
      errors++; $display("FAIL flush_idle_req actual=%b required=0", bus_req);
    end
    instrM = 32'd0; flush = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    instrM = mk(6'h23); memaddrM = 32'h500; causeM = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) begin
      errors++; $display("FAIL rst_pre_req actual=%b required=1", bus_req);
    end
    rst = 1'b0; instrM = 32'd0;
    @(negedge clk);
    checks++;
    if ({bus_req, stallM, load_valid, bus_be, loaddataM} !== 39'd0) begin
      errors++;
      $display("FAIL rst_mid_wait actual=req%b st%b lv%b be%b ld=%h required=all zero",
               bus_req, stallM, load_valid, bus_be, loaddataM);
    end
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    logic [31:0] r1, r2;
    r1 = $urandom; r2 = $urandom;
    run_txn(mk(6'h25), 32'h602, 32'd0, 32'd0, r1, 0, -1, o1);
    run_txn(mk(6'h24), 32'h605, 32'd0, 32'd0, r2, 1, -1, o2);
    checks++;
    if ({o1.ld, o2.ld} !== {exp_load(6'h25, 32'h602, r1), exp_load(6'h24, 32'h605, r2)}
        || o2.stall_cnt != 3) begin
      errors++;
      $display("FAIL b2b actual=%h %h stall%0d required=%h %h stall3", o1.ld, o2.ld,
               o2.stall_cnt, exp_load(6'h25, 32'h602, r1), exp_load(6'h24, 32'h605, r2));
    end
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checks++;
    if ({bus_req, stallM, load_valid} !== 3'b000) begin
      errors++;
      $display("FAIL stray_ack actual=req%b st%b lv%b required=000", bus_req, stallM, load_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_rand_loads();
    test_rand_stores();
    test_exceptions();
    test_timeout();
    test_flush();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
